// File: rtl/decode_scoreboard_pkg.sv
// Shared constants for the decode scoreboard: operand-select encodings and
// default parameter values.
package decode_pkg;

  localparam int NUM_REGS_DEF  = 32;
  localparam int NUM_FILES_DEF = 2;
  localparam int MAX_LAT_DEF   = 7;
  localparam int FWD_EN_DEF    = 1;

  // Operand source select; 2'b10 and 2'b11 are reserved and never driven.
  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_BYP = 2'b01;

  // Register-file select width, never narrower than one bit.
  function automatic int fsel_width(input int num_files);
    return (num_files <= 2) ? 1 : $clog2(num_files);
  endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode-stage <-> scoreboard bundle.
// Handshake: decode raises issue_valid with a stable instruction; the
// scoreboard answers with stall (the inverse of ready). The instruction
// leaves decode (issue_fire) in any cycle where issue_valid=1, stall=0 and
// flush=0; otherwise decode holds the same instruction and the PC.
interface decode_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int FSEL_W = 1,
  parameter int CNT_W  = 3,
  parameter int PCNT_W = 7
);
  logic              issue_valid;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [FSEL_W-1:0] rs_file;
  logic [FSEL_W-1:0] rt_file;
  logic              rs_used;
  logic              rt_used;
  logic [ADDR_W-1:0] rd_addr;
  logic [FSEL_W-1:0] rd_file;
  logic              rd_wr;
  logic [CNT_W-1:0]  rd_lat;
  logic              flush;
  logic              stall;
  logic              issue_fire;
  logic [1:0]        op_a_sel;
  logic [1:0]        op_b_sel;
  logic [PCNT_W-1:0] pending_cnt;

  modport master (
    output issue_valid, rs_addr, rt_addr, rs_file, rt_file, rs_used, rt_used,
    output rd_addr, rd_file, rd_wr, rd_lat, flush,
    input  stall, issue_fire, op_a_sel, op_b_sel, pending_cnt
  );

  modport slave (
    input  issue_valid, rs_addr, rt_addr, rs_file, rt_file, rs_used, rt_used,
    input  rd_addr, rd_file, rd_wr, rd_lat, flush,
    output stall, issue_fire, op_a_sel, op_b_sel, pending_cnt
  );
endinterface

// File: rtl/decode_scoreboard_entry.sv
// One scoreboard entry: a cycles-to-writeback counter that reloads on issue
// and otherwise counts down to zero. Also reports whether it will be nonzero
// after the coming edge so the top can keep a registered occupancy count.
module sb_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_next_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload wins over the decrement; an idle counter rests at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared without draining on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign nz_next_o = (cnt_d != '0);

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: tracks cycles-to-result for every register of
// every register file, stalls decode on RAW/WAW hazards and selects the
// final-stage bypass for results that land next cycle.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_FILES = NUM_FILES_DEF,
  parameter int MAX_LAT   = MAX_LAT_DEF,
  parameter int FWD_EN    = FWD_EN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  decode_scoreboard_if.slave  sb_if
);

  localparam int ADDR_W  = $clog2(NUM_REGS);
  localparam int FSEL_W  = fsel_width(NUM_FILES);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int NUM_ENT = NUM_FILES * NUM_REGS;
  localparam int IDX_W   = (NUM_ENT <= 2) ? 1 : $clog2(NUM_ENT);
  localparam int PCNT_W  = $clog2(NUM_ENT + 1);

  logic [CNT_W-1:0]   cnt [NUM_ENT];
  logic [NUM_ENT-1:0] nz_next;
  logic [CNT_W-1:0]   lat_sat;
  logic [CNT_W-1:0]   rs_cnt, rt_cnt, rd_cnt;
  logic               haz_a, haz_b, haz_waw;
  logic               stall, fire, track_rd;
  logic [1:0]         sel_a, sel_b;
  logic [PCNT_W-1:0]  pend_d, pend_q;

  // Counter of one (file, addr) entry; out-of-range selects read as idle.
  function automatic logic [CNT_W-1:0] cnt_at(
    input logic [CNT_W-1:0]  arr [NUM_ENT],
    input logic [FSEL_W-1:0] f,
    input logic [ADDR_W-1:0] a
  );
    int i;
    i = int'(f) * NUM_REGS + int'(a);
    cnt_at = '0;
    if (int'(f) < NUM_FILES && int'(a) < NUM_REGS) begin
      cnt_at = arr[IDX_W'(i)];
    end
  endfunction

  // Hazard detection, operand selection and issue decision.
  always_comb begin
    lat_sat = sb_if.rd_lat;
    if (int'(sb_if.rd_lat) > MAX_LAT) begin
      lat_sat = CNT_W'(MAX_LAT);
    end
    // Sources and destination all see the counters before this issue.
    rs_cnt = cnt_at(cnt, sb_if.rs_file, sb_if.rs_addr);
    rt_cnt = cnt_at(cnt, sb_if.rt_file, sb_if.rt_addr);
    rd_cnt = cnt_at(cnt, sb_if.rd_file, sb_if.rd_addr);

    haz_a = sb_if.rs_used &&
            ((rs_cnt > CNT_W'(1)) || (rs_cnt == CNT_W'(1) && FWD_EN == 0));
    haz_b = sb_if.rt_used &&
            ((rt_cnt > CNT_W'(1)) || (rt_cnt == CNT_W'(1) && FWD_EN == 0));
    // Younger writer must not land before an older one to the same register.
    haz_waw = sb_if.rd_wr && (rd_cnt > lat_sat);

    sel_a = SEL_REG;
    if (sb_if.rs_used && rs_cnt == CNT_W'(1) && FWD_EN != 0) begin
      sel_a = SEL_BYP;
    end
    sel_b = SEL_REG;
    if (sb_if.rt_used && rt_cnt == CNT_W'(1) && FWD_EN != 0) begin
      sel_b = SEL_BYP;
    end

    stall    = sb_if.issue_valid && (haz_a || haz_b || haz_waw);
    fire     = sb_if.issue_valid && !stall && !sb_if.flush;
    track_rd = fire && sb_if.rd_wr && (lat_sat != '0);
  end

  // Entry array; GPR r0 is hardwired to zero and never tracked.
  for (genvar f = 0; f < NUM_FILES; f++) begin : g_file
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      localparam int E = f * NUM_REGS + r;
      if (f == 0 && r == 0) begin : g_tie
        assign cnt[E]     = '0;
        assign nz_next[E] = 1'b0;
      end else begin : g_ent
        logic load_e;
        assign load_e = track_rd &&
                        (sb_if.rd_file == FSEL_W'(f)) &&
                        (sb_if.rd_addr == ADDR_W'(r));
        sb_entry #(.CNT_W(CNT_W)) u_ent (
          .clk        (clk),
          .reset      (reset),
          .load_i     (load_e),
          .load_val_i (lat_sat),
          .cnt_o      (cnt[E]),
          .nz_next_o  (nz_next[E])
        );
      end
    end
  end

  // Occupancy after the coming edge.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      pend_d = pend_d + PCNT_W'(nz_next[i]);
    end
  end

  // Registered occupancy count, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign sb_if.stall       = stall;
  assign sb_if.issue_fire  = fire;
  assign sb_if.op_a_sel    = sel_a;
  assign sb_if.op_b_sel    = sel_b;
  assign sb_if.pending_cnt = pend_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: one instance with bypass enabled,
// one with bypass disabled, both driven with identical stimulus.
module tb_decode_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];

  decode_scoreboard_if #(.ADDR_W(5), .FSEL_W(1), .CNT_W(3), .PCNT_W(7)) if_fwd ();
  decode_scoreboard_if #(.ADDR_W(5), .FSEL_W(1), .CNT_W(3), .PCNT_W(7)) if_nf ();

  decode_scoreboard #(.FWD_EN(1)) u_dut_fwd (.clk(clk), .reset(reset), .sb_if(if_fwd));
  decode_scoreboard #(.FWD_EN(0)) u_dut_nf  (.clk(clk), .reset(reset), .sb_if(if_nf));

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic drv(input logic v,
                     input logic [4:0] rs, input logic rsf, input logic rsu,
                     input logic [4:0] rt, input logic rtf, input logic rtu,
                     input logic [4:0] rd, input logic rdf, input logic rdw,
                     input logic [2:0] lat, input logic fl);
    if_fwd.issue_valid = v;  if_nf.issue_valid = v;
    if_fwd.rs_addr = rs;     if_nf.rs_addr = rs;
    if_fwd.rs_file = rsf;    if_nf.rs_file = rsf;
    if_fwd.rs_used = rsu;    if_nf.rs_used = rsu;
    if_fwd.rt_addr = rt;     if_nf.rt_addr = rt;
    if_fwd.rt_file = rtf;    if_nf.rt_file = rtf;
    if_fwd.rt_used = rtu;    if_nf.rt_used = rtu;
    if_fwd.rd_addr = rd;     if_nf.rd_addr = rd;
    if_fwd.rd_file = rdf;    if_nf.rd_file = rdf;
    if_fwd.rd_wr = rdw;      if_nf.rd_wr = rdw;
    if_fwd.rd_lat = lat;     if_nf.rd_lat = lat;
    if_fwd.flush = fl;       if_nf.flush = fl;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] rd, input logic rdf, input logic [2:0] lat);
    drv(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rd, rdf, 1'b1, lat, 1'b0);
  endtask

  task automatic rd_rs(input logic [4:0] a, input logic f);
    drv(1'b1, a, f, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rd_rt(input logic [4:0] a, input logic f);
    drv(1'b1, 5'd0, 1'b0, 1'b0, a, f, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next();
    reset = 1'b0;
  endtask

  // Stimulus
  initial begin
    idle();
    next();
    next();

    // Reset state: no counters, so nothing stalls and issue follows valid.
    rd_rs(5'd5, 1'b0);
    #1;
    chk("rst_stall", if_fwd.stall, 0);
    chk("rst_sel_a", if_fwd.op_a_sel, 0);
    chk("rst_fire", if_fwd.issue_fire, 1);
    chk("rst_pend", if_fwd.pending_cnt, 0);
    reset = 1'b0;
    next();

    // Latency-1 producer followed by consumer, with and without bypass.
    do_reset();
    wr(5'd5, 1'b0, 3'd1);
    #1;
    chk("fwd_wr_fire", if_fwd.issue_fire, 1);
    chk("nf_wr_fire", if_nf.issue_fire, 1);
    next();
    rd_rs(5'd5, 1'b0);
    #1;
    chk("fwd_stall", if_fwd.stall, 0);
    chk("fwd_sel_a", if_fwd.op_a_sel, 1);
    chk("fwd_fire", if_fwd.issue_fire, 1);
    chk("fwd_pend1", if_fwd.pending_cnt, 1);
    chk("nf_stall", if_nf.stall, 1);
    chk("nf_sel_a", if_nf.op_a_sel, 0);
    chk("nf_fire", if_nf.issue_fire, 0);
    next();
    #1;
    chk("nf_stall2", if_nf.stall, 0);
    chk("nf_sel_a2", if_nf.op_a_sel, 0);
    chk("nf_fire2", if_nf.issue_fire, 1);
    chk("fwd_pend0", if_fwd.pending_cnt, 0);
    next();

    // Load-use on rt with latency 2.
    do_reset();
    wr(5'd3, 1'b0, 3'd2);
    next();
    rd_rt(5'd3, 1'b0);
    #1;
    chk("lu_stall", if_fwd.stall, 1);
    chk("lu_sel_b0", if_fwd.op_b_sel, 0);
    chk("lu_pend_a", if_fwd.pending_cnt, 1);
    if_fwd.issue_valid = 1'b0;
    if_nf.issue_valid = 1'b0;
    #1;
    chk("lu_novalid_stall", if_fwd.stall, 0);
    chk("lu_novalid_fire", if_fwd.issue_fire, 0);
    next();
    rd_rt(5'd3, 1'b0);
    #1;
    chk("lu_stall2", if_fwd.stall, 0);
    chk("lu_sel_b1", if_fwd.op_b_sel, 1);
    chk("lu_pend_b", if_fwd.pending_cnt, 1);
    next();
    idle();
    #1;
    chk("lu_pend_c", if_fwd.pending_cnt, 0);
    next();

    // Separate files, then WAW ordering on f4.
    do_reset();
    wr(5'd4, 1'b1, 3'd6);
    next();
    wr(5'd4, 1'b0, 3'd1);
    #1;
    chk("file_stall", if_fwd.stall, 0);
    chk("file_fire", if_fwd.issue_fire, 1);
    next();
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      wr(5'd4, 1'b1, 3'd2);
      #1;
      if (i == 0) chk("waw_pend2", if_fwd.pending_cnt, 2);
      e = exp_q.pop_front();
      chk($sformatf("waw_stall_%0d", i), if_fwd.stall, e);
      chk($sformatf("waw_fire_%0d", i), if_fwd.issue_fire, {31'd0, ~e[0]});
      next();
    end
    idle();
    #1;
    chk("waw_pend1", if_fwd.pending_cnt, 1);
    next();

    // r0 is never tracked.
    do_reset();
    wr(5'd0, 1'b0, 3'd5);
    #1;
    chk("r0_fire", if_fwd.issue_fire, 1);
    next();
    drv(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    chk("r0_stall", if_fwd.stall, 0);
    chk("r0_sel_a", if_fwd.op_a_sel, 0);
    chk("r0_sel_b", if_fwd.op_b_sel, 0);
    chk("r0_pend", if_fwd.pending_cnt, 0);
    next();

    // Flushed issue loads nothing; reload overrides a decrement.
    do_reset();
    drv(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1, 3'd3, 1'b1);
    #1;
    chk("fl_fire", if_fwd.issue_fire, 0);
    next();
    rd_rs(5'd7, 1'b0);
    #1;
    chk("fl_stall", if_fwd.stall, 0);
    chk("fl_pend", if_fwd.pending_cnt, 0);
    next();
    wr(5'd9, 1'b0, 3'd3);
    next();
    idle();
    next();
    next();
    // r9 counter is 1 here; same instruction reads the old value.
    drv(1'b1, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 3'd4, 1'b0);
    #1;
    chk("rl_stall", if_fwd.stall, 0);
    chk("rl_sel_a", if_fwd.op_a_sel, 1);
    chk("rl_fire", if_fwd.issue_fire, 1);
    next();
    for (int i = 0; i < 3; i++) begin
      rd_rs(5'd9, 1'b0);
      #1;
      chk($sformatf("rl_wait_%0d", i), if_fwd.stall, 1);
      next();
    end
    rd_rs(5'd9, 1'b0);
    #1;
    chk("rl_done_stall", if_fwd.stall, 0);
    chk("rl_done_sel", if_fwd.op_a_sel, 1);
    next();

    // Reset with three entries pending.
    do_reset();
    wr(5'd1, 1'b0, 3'd7);
    next();
    wr(5'd2, 1'b0, 3'd7);
    next();
    wr(5'd3, 1'b1, 3'd7);
    next();
    drv(1'b1, 5'd1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    chk("mr_pend3", if_fwd.pending_cnt, 3);
    chk("mr_stall_pre", if_fwd.stall, 1);
    reset = 1'b1;
    next();
    reset = 1'b0;
    #1;
    chk("mr_pend0", if_fwd.pending_cnt, 0);
    chk("mr_stall", if_fwd.stall, 0);
    chk("mr_sel_a", if_fwd.op_a_sel, 0);
    chk("mr_sel_b", if_fwd.op_b_sel, 0);
    chk("mr_fire", if_fwd.issue_fire, 1);
    next();

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
